// File: rtl/ahb_pkg.sv
// ahb_pkg: shared types for the AHB-Lite to memory-controller bridge.
//   htrans_e        AHB transfer type encoding
//   HRESP_*         AHB response codes
//   mem_resp_e      memory-controller response encoding (2'b11 is treated as ERROR)
//   bridge_state_e  bridge control FSM states
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      MEM_WAIT  = 2'b00,
      MEM_OKAY  = 2'b01,
      MEM_ERROR = 2'b10
   } mem_resp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   // HSIZE code for a full-width transfer on a DataWidth-bit bus.
   function automatic logic [2:0] full_size_code(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating count of consecutive memory WAIT cycles.
//   clk, nReset  clock, asynchronous active-low reset
//   clear        zero the count (takes priority over inc)
//   inc          count one WAIT cycle
//   expired      the current WAIT cycle is the TimeoutCycles-th one; never
//                asserts when TimeoutCycles == 0
module mem_timeout_ctr #(
   parameter int TimeoutCycles = 255
) (
   input  logic clk,
   input  logic nReset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CntW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Not gated by inc so the FSM can combine it with its own WAIT decode
   // without forming a combinational loop through inc.
   assign expired = (TimeoutCycles != 0) && (cnt_q >= CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/ahb_mem_bridge.sv
// ahb_mem_bridge: AHB-Lite subordinate issuing single-beat memory requests.
//   clk, nReset                      clock, asynchronous active-low reset
//   HSEL/HADDR/HWRITE/HTRANS/HSIZE   AHB address phase
//   HWDATA, HREADY                   AHB write data (data phase), bus ready
//   HREADYOUT/HRESP/HRDATA           AHB subordinate response
//   memReq/memAddr/memWData/memWrite request to memory controller
//   memResp/memRData                 memory response (WAIT/OKAY/ERROR)
// Non-full-width transfers are rejected with a two-cycle ERROR and never
// reach memory. WAIT responses stretch the data phase until TimeoutCycles
// consecutive WAITs force an ERROR.
module ahb_mem_bridge import ahb_pkg::*; #(
   parameter int DataWidth     = 32,
   parameter int AddrWidth     = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 HSEL,
   input  logic [AddrWidth-1:0] HADDR,
   input  logic                 HWRITE,
   input  logic [1:0]           HTRANS,
   input  logic [2:0]           HSIZE,
   input  logic [DataWidth-1:0] HWDATA,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [DataWidth-1:0] HRDATA,
   output logic                 memReq,
   output logic [AddrWidth-1:0] memAddr,
   output logic [DataWidth-1:0] memWData,
   output logic                 memWrite,
   input  logic [1:0]           memResp,
   input  logic [DataWidth-1:0] memRData
);

   localparam logic [2:0] SizeCode = full_size_code(DataWidth);

   bridge_state_e        state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 write_q, write_d;

   logic          accept;
   logic          size_ok;
   logic          take;
   bridge_state_e accept_state;
   logic          ctr_clear;
   logic          ctr_inc;
   logic          expired;

   assign accept  = HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
   assign size_ok = (HSIZE == SizeCode);

   // Where the FSM goes from any point that may start a new transfer.
   always_comb begin
      accept_state = ST_IDLE;
      if (accept) begin
         accept_state = size_ok ? ST_ACCESS : ST_ERR1;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      write_d   = write_q;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = '0;
      memReq    = 1'b0;
      memAddr   = '0;
      memWData  = '0;
      memWrite  = 1'b0;
      ctr_clear = 1'b1;
      ctr_inc   = 1'b0;
      take      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            take    = 1'b1;
            state_d = accept_state;
         end
         ST_ACCESS: begin
            memReq   = 1'b1;
            memAddr  = addr_q;
            memWrite = write_q;
            // Manager holds HWDATA stable while HREADYOUT is low.
            memWData = write_q ? HWDATA : '0;
            if (memResp == MEM_WAIT) begin
               HREADYOUT = 1'b0;
               ctr_clear = 1'b0;
               ctr_inc   = 1'b1;
               if (expired) begin
                  state_d = ST_ERR1;
               end
            end else if (memResp == MEM_OKAY) begin
               if (!write_q) begin
                  HRDATA = memRData;
               end
               // Completing data phase overlaps the next address phase.
               take    = 1'b1;
               state_d = accept_state;
            end else begin
               HREADYOUT = 1'b0;
               state_d   = ST_ERR1;
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP   = HRESP_ERROR;
            take    = 1'b1;
            state_d = accept_state;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (take && accept) begin
         addr_d  = HADDR;
         write_d = HWRITE;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
      end
   end

   mem_timeout_ctr #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timeout (
      .clk    (clk),
      .nReset (nReset),
      .clear  (ctr_clear),
      .inc    (ctr_inc),
      .expired(expired)
   );

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// tb_ahb_mem_bridge: directed stimulus with a per-cycle expected-response
// scoreboard. The driver pushes the expected bridge outputs for every cycle
// it drives; an independent monitor pops and compares on the falling edge.
module tb_ahb_mem_bridge;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic        HWRITE = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [2:0]  HSIZE = 3'd2;
   logic [31:0] HWDATA = '0;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        memReq;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic        memWrite;
   logic [1:0]  memResp = 2'b00;
   logic [31:0] memRData = '0;

   // Single subordinate on the bus: bus ready follows our own ready.
   assign HREADY = HREADYOUT;

   always #5 clk = ~clk;

   ahb_mem_bridge #(
      .DataWidth(32),
      .AddrWidth(32),
      .TimeoutCycles(4)
   ) dut (
      .clk(clk), .nReset(nReset),
      .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .memReq(memReq), .memAddr(memAddr), .memWData(memWData),
      .memWrite(memWrite), .memResp(memResp), .memRData(memRData)
   );

   typedef struct packed {
      logic        rdy;
      logic        resp;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic        mwr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic exp_t ex(input logic rdy, input logic resp,
                               input logic [31:0] rdata, input logic req,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic wr);
      exp_t e;
      e = '{rdy, resp, rdata, req, a, wd, wr};
      return e;
   endfunction

   function automatic exp_t idle_e();
      return ex(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endfunction

   task automatic drive(input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [1:0] resp, input logic [31:0] rdata,
                        input exp_t e);
      @(posedge clk);
      #1;
      HSEL     = sel;
      HTRANS   = trans;
      HADDR    = addr;
      HWRITE   = wr;
      HSIZE    = size;
      HWDATA   = wdata;
      memResp  = resp;
      memRData = rdata;
      exp_q.push_back(e);
   endtask

   task automatic idle(input exp_t e);
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, e);
   endtask

   // Read with a single erroring memory response, then the two-cycle ERROR.
   task automatic err_read(input logic [31:0] addr, input logic [1:0] resp);
      drive(1'b1, 2'b10, addr, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, resp, 32'hBAD0BAD0,
            ex(1'b0, 1'b0, 32'h0, 1'b1, addr, 32'h0, 1'b0));
      idle(ex(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      idle(ex(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      idle(idle_e());
   endtask

   // Monitor / checker.
   initial begin
      exp_t e;
      exp_t got;
      int   cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{HREADYOUT, HRESP, HRDATA, memReq, memAddr, memWData, memWrite};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL trace[%0d]: got rdy=%b resp=%b rdata=%h req=%b addr=%h wdata=%h wr=%b, exp rdy=%b resp=%b rdata=%h req=%b addr=%h wdata=%h wr=%b",
                        cyc, got.rdy, got.resp, got.rdata, got.req, got.maddr,
                        got.mwdata, got.mwr, e.rdy, e.resp, e.rdata, e.req,
                        e.maddr, e.mwdata, e.mwr);
            end
            cyc++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset values.
      idle(idle_e());
      idle(idle_e());
      nReset = 1'b1;
      idle(idle_e());

      // Zero-wait write.
      drive(1'b1, 2'b10, 32'h100, 1'b1, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'hDEADBEEF, 2'b01, 32'h0,
            ex(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1));
      idle(idle_e());

      // Read with three WAITs (HSEL dropped while stalled), then OKAY.
      drive(1'b1, 2'b10, 32'h200, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b00, 32'hAAAA5555,
               ex(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h0, 1'b0));
      end
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b01, 32'h12345678,
            ex(1'b1, 1'b0, 32'h12345678, 1'b1, 32'h200, 32'h0, 1'b0));
      idle(idle_e());

      // Memory ERROR and the reserved 2'b11 code.
      err_read(32'h300, 2'b10);
      err_read(32'h304, 2'b11);

      // Byte write rejected; a read accepted in ERR2 proceeds normally.
      drive(1'b1, 2'b10, 32'h400, 1'b1, 3'd0, 32'h0, 2'b01, 32'h0, idle_e());
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h55, 2'b01, 32'h0,
            ex(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      drive(1'b1, 2'b10, 32'h600, 1'b0, 3'd2, 32'h0, 2'b01, 32'h0,
            ex(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b01, 32'h0000600D,
            ex(1'b1, 1'b0, 32'h0000600D, 1'b1, 32'h600, 32'h0, 1'b0));
      idle(idle_e());

      // Timeout after four WAIT cycles.
      drive(1'b1, 2'b10, 32'h500, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0,
               ex(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 32'h0, 1'b0));
      end
      idle(ex(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      idle(ex(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
      idle(idle_e());

      // BUSY and unselected NONSEQ are ignored.
      drive(1'b1, 2'b01, 32'h900, 1'b1, 3'd2, 32'h0, 2'b01, 32'h0, idle_e());
      drive(1'b0, 2'b10, 32'h904, 1'b1, 3'd2, 32'h0, 2'b01, 32'h0, idle_e());
      idle(idle_e());

      // Back-to-back write (NONSEQ) then read (SEQ), no idle gap.
      drive(1'b1, 2'b10, 32'h0, 1'b1, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      drive(1'b1, 2'b11, 32'h4, 1'b0, 3'd2, 32'h11111111, 2'b01, 32'h0,
            ex(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h11111111, 1'b1));
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b01, 32'hCAFEF00D,
            ex(1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 32'h4, 32'h0, 1'b0));
      idle(idle_e());

      // Reset asserted in the middle of a stalled read.
      drive(1'b1, 2'b10, 32'h700, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0,
            ex(1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 32'h0, 1'b0));
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      #1 nReset = 1'b0;
      idle(idle_e());
      nReset = 1'b1;
      idle(idle_e());

      // A fresh transfer after reset still completes normally.
      drive(1'b1, 2'b10, 32'h800, 1'b0, 3'd2, 32'h0, 2'b00, 32'h0, idle_e());
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 2'b01, 32'h87654321,
            ex(1'b1, 1'b0, 32'h87654321, 1'b1, 32'h800, 32'h0, 1'b0));
      idle(idle_e());

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
